// File: rtl/tpu_result_capture.sv
// tpu_result_capture: tags valid MLP accumulator pairs with their layer and queues them in a FWFT FIFO.
// Latency: a sample accepted at edge N is on rd_* with rd_valid=1 right after edge N.
// Backpressure: rd_valid/rd_ready drain port; a full FIFO drops new samples unless the head pops that cycle.

module tpu_result_capture_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wr_dat,
   output logic [W-1:0]             rd_dat,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; pointers and count alone define validity.
   always_ff @(posedge clk) begin
      if (push && !(rst || flush)) mem[wr_ptr] <= wr_dat;
   end

   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign rd_dat = empty ? '0 : mem[rd_ptr];
endmodule

module tpu_result_capture #(
   parameter int         DEPTH      = 16,
   parameter logic [2:0] LAST_LAYER = 3'd1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     capture_en,
   input  logic                     acc_valid,
   input  logic signed [31:0]       acc0,
   input  logic signed [31:0]       acc1,
   input  logic [2:0]               layer,
   input  logic                     layer_complete,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic signed [31:0]       rd_acc0,
   output logic signed [31:0]       rd_acc1,
   output logic [2:0]               rd_layer,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic [7:0]               dropped_cnt,
   output logic [3:0]               layers_done,
   output logic [1:0]               state_dbg
);
   typedef struct packed {
      logic [2:0]  layer;
      logic [31:0] acc0;
      logic [31:0] acc1;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t state;
   logic   lc_q;
   logic   lc_rise;
   logic   wr_req;
   logic   pop;
   logic   push;
   logic   drop;
   entry_t wr_ent;
   entry_t rd_ent;

   assign lc_rise = layer_complete & ~lc_q;
   assign wr_req  = (state == S_CAPTURE) & acc_valid;
   assign pop     = rd_valid & rd_ready;
   // A pop frees the head slot this cycle, so a full FIFO still takes the new sample.
   assign push    = wr_req & (~full | pop);
   assign drop    = wr_req & ~push;
   assign wr_ent  = '{layer: layer, acc0: acc0, acc1: acc1};

   tpu_result_capture_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(entry_t))
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .flush  (clear),
      .push   (push),
      .pop    (pop),
      .wr_dat (wr_ent),
      .rd_dat (rd_ent),
      .count  (count),
      .full   (full),
      .empty  (empty)
   );

   assign rd_valid  = ~empty;
   assign rd_acc0   = rd_ent.acc0;
   assign rd_acc1   = rd_ent.acc1;
   assign rd_layer  = rd_ent.layer;
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state       <= S_IDLE;
         lc_q        <= 1'b0;
         overflow    <= 1'b0;
         dropped_cnt <= '0;
         layers_done <= '0;
      end else begin
         lc_q <= layer_complete;
         if (drop) begin
            overflow <= 1'b1;
            if (dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 8'd1;
         end
         if (state == S_CAPTURE && lc_rise && layers_done != 4'hF)
            layers_done <= layers_done + 4'd1;
         case (state)
            S_IDLE:    if (capture_en) state <= S_CAPTURE;
            S_CAPTURE: begin
               if (!capture_en)                           state <= S_IDLE;
               else if (lc_rise && layer == LAST_LAYER)   state <= S_HOLD;
            end
            S_HOLD:    if (!capture_en) state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end
endmodule
